// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton conditioning front end.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    localparam int MS_PER_S = 1000;

    // Last value of the 1 ms prescaler; it counts 0..prescale_term and wraps.
    function automatic int prescale_term(input int clk_hz);
        return (clk_hz / MS_PER_S) - 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: two-flop synchroniser, debounce FSM, press/release
// pulse generation and optional auto-repeat while the key is held.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic tick_1ms,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DEB_W  = $clog2(DEBOUNCE_MS + 1);
    localparam int HOLD_W = $clog2(REPEAT_DELAY_MS + 1);
    localparam int RPT_W  = (REPEAT_RATE_MS > 1) ? $clog2(REPEAT_RATE_MS) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(REPEAT_DELAY_MS);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_RATE_MS - 1);

    logic              sync1_q;
    logic              sync2_q;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;

    logic              deb_done;
    logic              repeat_fire;
    logic              release_accept;

    // The debounce window closes on the tick that completes DEBOUNCE_MS stable ms.
    // The entry cycle may already have counted one tick, hence >= rather than ==.
    assign deb_done       = tick_1ms && (deb_q >= DEB_LAST);
    assign release_accept = (state_q == RELEASE_WAIT) && !sync2_q && deb_done;

    // Two-flop synchroniser; only the second flop feeds the debounce logic.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a level change is only accepted after a full debounce window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RELEASED:     if (sync2_q) state_d = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!sync2_q)      state_d = RELEASED;
                else if (deb_done) state_d = PRESSED;
            end
            PRESSED:      if (!sync2_q) state_d = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (sync2_q)       state_d = PRESSED;
                else if (deb_done) state_d = RELEASED;
            end
            default:      state_d = RELEASED;
        endcase
    end

    // Counter and output next values: debounce count, hold/repeat timing, pulses.
    always_comb begin
        deb_d       = deb_q;
        hold_d      = hold_q;
        rpt_d       = rpt_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_fire = 1'b0;

        // Hold and repeat timing only runs while the key is accepted as down.
        if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
            if (!repeat_en) begin
                // Disabling repeat forgets all progress; re-enabling restarts the delay.
                hold_d = '0;
                rpt_d  = '0;
            end else if (tick_1ms) begin
                if (hold_q != HOLD_FULL) begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_q == HOLD_LAST) begin
                        repeat_fire = 1'b1;
                        rpt_d       = '0;
                    end
                end else if (rpt_q == RPT_LAST) begin
                    repeat_fire = 1'b1;
                    rpt_d       = '0;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
        end

        case (state_q)
            RELEASED: begin
                level_d = 1'b0;
                hold_d  = '0;
                rpt_d   = '0;
                // Preload so a tick on the entry cycle counts toward the window.
                deb_d   = DEB_W'(tick_1ms);
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    deb_d = '0;
                end else if (deb_done) begin
                    deb_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                    rpt_d   = '0;
                end else if (tick_1ms) begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                deb_d   = DEB_W'(tick_1ms);
                press_d = repeat_fire;
            end
            RELEASE_WAIT: begin
                if (!sync2_q) begin
                    if (deb_done) begin
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else if (tick_1ms) begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
                // An accepted release suppresses a repeat landing on the same tick.
                press_d = repeat_fire && !release_accept;
            end
            default: begin
                deb_d = '0;
            end
        endcase
    end

    // Counter and registered output state.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            deb_q     <= '0;
            hold_q    <= '0;
            rpt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            rpt_q     <= rpt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Board-level pushbutton front end: a shared 1 ms prescaler fanned out to
// N_BTN independent synchronise/debounce/repeat channels.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 8,
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             tick_1ms
);

    localparam int PRE_TERM = prescale_term(CLK_HZ);
    localparam int PRE_W    = (PRE_TERM > 0) ? $clog2(PRE_TERM + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_TERM);

    logic [PRE_W-1:0] pre_q, pre_d;

    assign tick_1ms = (pre_q == PRE_LAST);

    // Prescaler wraps on its terminal count, which is also the tick cycle.
    always_comb begin
        pre_d = tick_1ms ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
        ) u_chan (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .tick_1ms   (tick_1ms),
            .btn_raw    (btn_raw[i]),
            .repeat_en  (repeat_en[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at sim rates: tick every 10 clocks,
// 4 ms debounce, 20 ms repeat delay, 5 ms repeat rate.
module tb_button_conditioner;

    localparam int N     = 8;
    localparam int CLKHZ = 10_000;
    localparam int DEB   = 4;
    localparam int DLY   = 20;
    localparam int RATE  = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw;
    logic [N-1:0] rep;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic         tick;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (N),
        .CLK_HZ         (CLKHZ),
        .DEBOUNCE_MS    (DEB),
        .REPEAT_DELAY_MS(DLY),
        .REPEAT_RATE_MS (RATE)
    ) dut (
        .clk_100MHz (clk),
        .reset      (rst_n),
        .btn_raw    (raw),
        .repeat_en  (rep),
        .btn_level  (lvl),
        .btn_press  (prs),
        .btn_release(rel),
        .tick_1ms   (tick)
    );

    int nvec = 0;
    int nmis = 0;

    int cyc = 0;
    int press_cnt [N] = '{default: 0};
    int rel_cnt   [N] = '{default: 0};
    int last_press[N] = '{default: -1};
    int p2_times[$];
    int both_cnt  = 0;
    int tick_cnt  = 0;
    int last_tick = -1;
    int prev_tick = -1;

    always @(posedge clk) cyc++;

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (prs[i]) begin
                press_cnt[i]++;
                last_press[i] = cyc;
                if (i == 2) p2_times.push_back(cyc);
            end
            if (rel[i]) rel_cnt[i]++;
            if (prs[i] && rel[i]) both_cnt++;
        end
        if (tick) begin
            tick_cnt++;
            prev_tick = last_tick;
            last_tick = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp[N];
        int sr[N];
        int t0, lat, base, others, n;

        rst_n = 1'b0;
        raw   = '0;
        rep   = '0;
        cycles(3);
        chk("rst_level",   int'(lvl),  0);
        chk("rst_press",   int'(prs),  0);
        chk("rst_release", int'(rel),  0);
        chk("rst_tick",    int'(tick), 0);

        rst_n = 1'b1;
        cycles(30);
        chk("tick_count",  tick_cnt, 3);
        chk("tick_period", last_tick - prev_tick, 10);

        // Clean press on channel 0.
        sp = press_cnt; sr = rel_cnt;
        raw[0] = 1'b1; t0 = cyc;
        cycles(100);
        chk("clean_cnt", press_cnt[0] - sp[0], 1);
        lat = last_press[0] - t0;
        chk($sformatf("clean_lat_%0d_in_32_42", lat), int'(lat >= 32 && lat <= 42), 1);
        chk("clean_level", int'(lvl), 8'h01);
        others = 0;
        for (int i = 1; i < N; i++) others += press_cnt[i] - sp[i];
        chk("clean_others", others, 0);
        raw[0] = 1'b0;
        cycles(60);
        chk("clean_rel", rel_cnt[0] - sr[0], 1);
        chk("clean_level_off", int'(lvl), 0);

        // Bounce on channel 1: 15-clock phases never span a debounce window.
        sp = press_cnt;
        for (int k = 0; k < 14; k++) begin
            raw[1] = ~raw[1];
            cycles(15);
        end
        chk("bounce_quiet", press_cnt[1] - sp[1], 0);
        chk("bounce_level", int'(lvl[1]), 0);
        raw[1] = 1'b1; t0 = cyc;
        cycles(60);
        chk("bounce_cnt", press_cnt[1] - sp[1], 1);
        lat = last_press[1] - t0;
        chk($sformatf("bounce_lat_%0d_in_32_42", lat), int'(lat >= 32 && lat <= 42), 1);
        raw[1] = 1'b0;
        cycles(60);

        // Auto-repeat on channel 2: presses at acc, acc+200, +250, +300, +350
        // inside the 400-clock hold. Release arrives exactly at acc+400, where
        // the next repeat would land, so it must be suppressed.
        rep[2] = 1'b1;
        sp = press_cnt; sr = rel_cnt; base = p2_times.size();
        raw[2] = 1'b1;
        cycles(400);
        chk("rpt_cnt", press_cnt[2] - sp[2], 5);
        if (p2_times.size() - base >= 3) begin
            chk("rpt_delay", p2_times[base+1] - p2_times[base], 200);
            chk("rpt_rate",  p2_times[base+2] - p2_times[base+1], 50);
        end else begin
            chk("rpt_times", p2_times.size() - base, 3);
        end
        raw[2] = 1'b0;
        for (int k = 0; k < 100 && rel_cnt[2] == sr[2]; k++) cycles(1);
        chk("rpt_rel", rel_cnt[2] - sr[2], 1);
        chk("rpt_rel_wins", press_cnt[2] - sp[2], 5);
        cycles(60);
        chk("rpt_quiet", press_cnt[2] - sp[2], 5);
        chk("rpt_level_off", int'(lvl[2]), 0);

        // Repeat disabled after the second repeat: nothing more while held.
        sp = press_cnt; sr = rel_cnt; base = p2_times.size();
        raw[2] = 1'b1; t0 = cyc;
        for (int k = 0; k < 400 && (p2_times.size() - base) < 3; k++) cycles(1);
        rep[2] = 1'b0;
        chk("dis_reached", p2_times.size() - base, 3);
        n = 400 - (cyc - t0);
        if (n > 0) cycles(n);
        chk("dis_quiet", press_cnt[2] - sp[2], 3);
        chk("dis_level", int'(lvl[2]), 1);
        raw[2] = 1'b0;
        cycles(60);
        chk("dis_rel", rel_cnt[2] - sr[2], 1);

        // Simultaneous presses on channels 0 and 7.
        sp = press_cnt;
        raw[0] = 1'b1; raw[7] = 1'b1;
        cycles(60);
        chk("sim_cnt0", press_cnt[0] - sp[0], 1);
        chk("sim_cnt7", press_cnt[7] - sp[7], 1);
        chk("sim_same_cycle", last_press[7], last_press[0]);
        chk("sim_level", int'(lvl), 8'h81);

        // Async reset 20 clocks into channel 3's debounce; 0 and 7 stay held.
        sp = press_cnt;
        raw[3] = 1'b1;
        cycles(20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level",   int'(lvl), 0);
        chk("arst_press",   int'(prs), 0);
        chk("arst_release", int'(rel), 0);
        cycles(5);
        rst_n = 1'b1; t0 = cyc;
        cycles(60);
        chk("arst_cnt3", press_cnt[3] - sp[3], 1);
        lat = last_press[3] - t0;
        chk($sformatf("arst_lat_%0d_in_35_45", lat), int'(lat >= 35 && lat <= 45), 1);
        chk("arst_fresh0", press_cnt[0] - sp[0], 1);
        chk("arst_level", int'(lvl), 8'h89);

        raw = '0;
        cycles(60);
        chk("final_level", int'(lvl), 0);
        chk("press_release_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
